// File: rtl/bit_serializer_pkg.sv
// Shared types and defaults for the bit_serializer block.
//   state_t        : serializer FSM state (IDLE, SHIFT)
//   DefaultWidth   : default parallel word width
//   DefaultIdleBit : default serial line level when no data bit is valid
package bit_serializer_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int unsigned DefaultWidth   = 8;
    localparam logic        DefaultIdleBit = 1'b0;

endpackage

// File: rtl/word_hold_buf.sv
// One-entry hold buffer for the serializer: parks the next word while the
// current word is still shifting.
//   clk   : system clock
//   rst   : synchronous active-high reset, empties the buffer
//   load  : capture data, mark full
//   data  : word to capture
//   drain : release the held word (never asserted together with load)
//   full  : a word is held
//   q     : held word
module word_hold_buf
    import bit_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             drain,
    output logic             full,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic             full_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= '0;
            full_q <= 1'b0;
        end else if (load) begin
            q_q    <= data;
            full_q <= 1'b1;
        end else if (drain) begin
            full_q <= 1'b0;
        end
    end

    assign full = full_q;
    assign q    = q_q;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end. Accepts WIDTH-bit words on a valid/ready
// handshake and emits one bit per clock; a one-entry hold buffer keeps
// back-to-back words gapless. The line rests at IDLE_BIT when no bit is valid.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   data_in    : parallel word, sampled on data_valid && data_ready
//   data_valid : upstream word present
//   data_ready : a word can be accepted this cycle
//   serial_out : current serial bit, IDLE_BIT when idle
//   bit_valid  : serial_out carries a data bit
//   word_start : first bit of a word
//   busy       : shifting, or hold buffer full
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = DefaultWidth,
    parameter bit          MSB_FIRST = 1'b1,
    parameter logic        IDLE_BIT  = DefaultIdleBit
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             serial_out,
    output logic             bit_valid,
    output logic             word_start,
    output logic             busy
);

    if (WIDTH < 2) begin : g_width_check
        $error("bit_serializer: WIDTH must be >= 2");
    end

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic             hb_load;
    logic             hb_drain;
    logic             hb_full;
    logic [WIDTH-1:0] hb_q;

    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] sreg_shifted;

    word_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk   (clk),
        .rst   (rst),
        .load  (hb_load),
        .data  (data_in),
        .drain (hb_drain),
        .full  (hb_full),
        .q     (hb_q)
    );

    assign data_ready = ~hb_full & ~rst;
    assign accept     = data_valid & data_ready;
    assign last_bit   = (cnt_q == LastIdx);

    // Shift toward whichever end feeds serial_out.
    assign sreg_shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                                    : {1'b0, sreg_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        hb_load  = 1'b0;
        hb_drain = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sreg_d  = data_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!last_bit) begin
                    sreg_d = sreg_shifted;
                    cnt_d  = cnt_q + CntW'(1);
                    if (accept) begin
                        hb_load = 1'b1;
                    end
                end else if (hb_full) begin
                    // data_ready is low here, so no accept can collide with the drain.
                    sreg_d   = hb_q;
                    hb_drain = 1'b1;
                    cnt_d    = '0;
                end else if (accept) begin
                    // Bypass straight into sreg to keep the stream gapless.
                    sreg_d = data_in;
                    cnt_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        bit_valid  = (state_q == SHIFT);
        serial_out = IDLE_BIT;
        if (state_q == SHIFT) begin
            serial_out = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
        end
        word_start = (state_q == SHIFT) && (cnt_q == '0);
        busy       = (state_q == SHIFT) || hb_full;
    end

endmodule
